// File: rtl/eth_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// eth_pkg : shared state encoding, framing constants and helpers for eth_tx_*
// Rev 1.0
// -----------------------------------------------------------------------------
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6
  } eth_state_e;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY     = 32'h04C1_1DB7;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_crc32.sv
`default_nettype none
// -----------------------------------------------------------------------------
// eth_tx_crc32 : byte-wide CRC-32 LFSR (MSB-first register, bit-reversed input)
// Rev 1.0
// -----------------------------------------------------------------------------
module eth_tx_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [7:0]  w_din;
  logic [31:0] w_next;

  assign w_din = bitrev8(data);

  always_comb begin
    w_next = crc;
    for (int i = 7; i >= 0; i--) begin
      if (w_next[31] ^ w_din[i]) w_next = {w_next[30:0], 1'b0} ^ CRC_POLY;
      else                       w_next = {w_next[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= w_next;
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_framer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// eth_tx_framer : GMII transmit framer (preamble, SFD, payload, pad, FCS, IFG)
// Build option ETH_TX_PAD_EN: zero-pad short frames up to MIN_FRAME bytes.
// Rev 1.0
// -----------------------------------------------------------------------------
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       underrun
);

  // The IDLE cycle preceding PRE contributes the final idle byte on the wire,
  // so IFG itself lasts one cycle less than the gap seen between frames.
  localparam logic [15:0] c_ifg_last = 16'(IFG_BYTES - 2);

  eth_state_e  r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_inc;
  logic        r_drop;
  logic [31:0] w_crc;
  logic [7:0]  w_crc_din, w_fcs_src;
  logic        w_crc_en, w_crc_init;
  logic [7:0]  w_txd_nxt;
  logic        w_en_nxt, w_er_nxt, w_ur_nxt;
  logic        w_pad_needed, w_pad_done;

  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

`ifdef ETH_TX_PAD_EN
  localparam logic [15:0] c_min_frame = 16'(MIN_FRAME);
  assign w_pad_needed = (w_cnt_inc <  c_min_frame);
  assign w_pad_done   = (w_cnt_inc >= c_min_frame);
`else
  logic w_unused_min_frame;
  assign w_unused_min_frame = ^MIN_FRAME;
  assign w_pad_needed       = 1'b0;
  assign w_pad_done         = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (s_valid && !r_drop) w_state_nxt = ST_PRE;
      ST_PRE:  if (r_cnt == 16'd6) w_state_nxt = ST_SFD;
      ST_SFD:  w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (!s_valid)    w_state_nxt = ST_IFG;
        else if (s_last) w_state_nxt = w_pad_needed ? ST_PAD : ST_FCS;
      end
      ST_PAD:  if (w_pad_done) w_state_nxt = ST_FCS;
      ST_FCS:  if (r_cnt == 16'd3) w_state_nxt = ST_IFG;
      ST_IFG:  if (r_cnt == c_ifg_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One counter serves as preamble/FCS/IFG index and as the frame byte count,
  // which carries over from DATA into PAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   r_cnt <= 16'd0;
    else if (w_state_nxt != r_state && w_state_nxt != ST_PAD) r_cnt <= 16'd0;
    else if (r_state != ST_IDLE)                               r_cnt <= w_cnt_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_drop <= 1'b0;
    else if (r_state == ST_DATA && !s_valid)    r_drop <= 1'b1;
    else if (r_drop && s_valid && s_last)       r_drop <= 1'b0;
  end

  assign w_fcs_src = (r_cnt[1:0] == 2'd0) ? w_crc[31:24] :
                     (r_cnt[1:0] == 2'd1) ? w_crc[23:16] :
                     (r_cnt[1:0] == 2'd2) ? w_crc[15:8]  : w_crc[7:0];

  always_comb begin
    s_ready    = (r_state == ST_DATA) || r_drop;
    w_txd_nxt  = 8'h00;
    w_en_nxt   = 1'b0;
    w_er_nxt   = 1'b0;
    w_ur_nxt   = 1'b0;
    w_crc_en   = 1'b0;
    w_crc_din  = s_data;
    w_crc_init = (r_state == ST_SFD);
    case (r_state)
      ST_PRE: begin
        w_txd_nxt = ETH_PREAMBLE;
        w_en_nxt  = 1'b1;
      end
      ST_SFD: begin
        w_txd_nxt = ETH_SFD;
        w_en_nxt  = 1'b1;
      end
      ST_DATA: begin
        w_en_nxt = 1'b1;
        if (s_valid) begin
          w_txd_nxt = s_data;
          w_crc_en  = 1'b1;
        end else begin
          w_er_nxt = 1'b1;
          w_ur_nxt = 1'b1;
        end
      end
      ST_PAD: begin
        w_en_nxt  = 1'b1;
        w_crc_en  = 1'b1;
        w_crc_din = 8'h00;
      end
      ST_FCS: begin
        w_txd_nxt = ~bitrev8(w_fcs_src);
        w_en_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      gmii_txd   <= w_txd_nxt;
      gmii_tx_en <= w_en_nxt;
      gmii_tx_er <= w_er_nxt;
      underrun   <= w_ur_nxt;
    end
  end

  eth_tx_crc32 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (w_crc_init),
    .en   (w_crc_en),
    .data (w_crc_din),
    .crc  (w_crc)
  );

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_framer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_eth_tx_framer : directed self-checking bench for eth_tx_framer
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_eth_tx_framer;
  import eth_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       underrun;

  always #4 clk = ~clk;

  eth_tx_framer #(.MIN_FRAME(60), .IFG_BYTES(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .gmii_tx_er (gmii_tx_er),
    .underrun   (underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // wire monitor: cumulative counters only, the stimulus side takes snapshots
  logic [7:0] rx_q[$];
  int frames_seen = 0, idle_run = 0, last_gap = -1;
  int er_cycles = 0, ur_cycles = 0, erur_cycles = 0, rdy_cycles = 0, rdy_gap = 0;
  bit prev_en = 1'b0;

  always @(negedge clk) begin
    if (gmii_tx_en) rx_q.push_back(gmii_txd);
    if (gmii_tx_er) er_cycles++;
    if (underrun) ur_cycles++;
    if (gmii_tx_en && gmii_tx_er && underrun && gmii_txd == 8'h00) erur_cycles++;
    if (s_ready) rdy_cycles++;
    if (s_ready && !gmii_tx_en) rdy_gap++;
    if (!gmii_tx_en) begin
      if (prev_en) begin idle_run = 1; frames_seen++; end
      else idle_run++;
    end else if (!prev_en) last_gap = idle_run;
    prev_en = gmii_tx_en;
  end

  int b_rx, b_frames, b_er, b_ur, b_erur, b_rdy, b_gap;
  logic [7:0] pay[$];

  task automatic snap();
    b_rx = rx_q.size(); b_frames = frames_seen; b_er = er_cycles; b_ur = ur_cycles;
    b_erur = erur_cycles; b_rdy = rdy_cycles; b_gap = rdy_gap;
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      logic fb;
      fb = c[31] ^ b[k];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    s_data = d; s_valid = 1'b1; s_last = last;
    @(negedge clk);
    while (!s_ready && t < 200) begin @(negedge clk); t++; end
    if (!s_ready) check("ready_timeout", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_payload(input int drop_at);
    for (int i = 0; i < pay.size(); i++) begin
      push_byte(pay[i], i == pay.size() - 1);
      if (i == drop_at - 1) begin
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_seen < b_frames + n && t < 3000) begin @(negedge clk); t++; end
    check("frame_done", 64'(frames_seen - b_frames), 64'(n));
    repeat (16) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    int body, total, got, e_pre, e_pay, e_pad;
    logic [31:0] c;
    body = pay.size();
`ifdef ETH_TX_PAD_EN
    if (body < 60) body = 60;
`endif
    total = 8 + body + 4;
    got   = rx_q.size() - b_rx;
    check({tag, "_len"}, 64'(got), 64'(total));
    e_pre = 0; e_pay = 0; e_pad = 0;
    if (got == total) begin
      for (int i = 0; i < 8; i++)
        if (rx_q[b_rx+i] !== ((i == 7) ? 8'hD5 : 8'h55)) e_pre++;
      for (int i = 0; i < body; i++) begin
        if (i < pay.size()) begin
          if (rx_q[b_rx+8+i] !== pay[i]) e_pay++;
        end else if (rx_q[b_rx+8+i] !== 8'h00) e_pad++;
      end
    end else e_pre = 1;
    check({tag, "_preamble_errs"}, 64'(e_pre), 64'd0);
    check({tag, "_payload_errs"}, 64'(e_pay), 64'd0);
    check({tag, "_pad_errs"}, 64'(e_pad), 64'd0);
    c = 32'hFFFF_FFFF;
    for (int i = b_rx + 8; i < rx_q.size(); i++) c = crc_step(c, rx_q[i]);
    check({tag, "_residue"}, 64'(c), 64'(CRC_RESIDUE));
  endtask

  task automatic check_fcs_123456789(input string tag);
    logic [7:0] exp_fcs[4];
    exp_fcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    if (rx_q.size() - b_rx == 21) begin
      for (int k = 0; k < 4; k++)
        check($sformatf("%s_fcs%0d", tag, k), 64'(rx_q[b_rx+17+k]), 64'(exp_fcs[k]));
    end else check({tag, "_fcs_len"}, 64'(rx_q.size() - b_rx), 64'd21);
  endtask

  task automatic load_ascii9();
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 64'(gmii_txd), 64'h00);
    check("rst_tx_en", 64'(gmii_tx_en), 64'd0);
    check("rst_tx_er", 64'(gmii_tx_er), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_crc", 64'(dut.u_crc.crc), 64'hFFFF_FFFF);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // "123456789": known FCS 26 39 F4 CB, 21 tx_en cycles without padding
    load_ascii9(); snap();
    send_payload(-1); wait_frames(1);
    check_frame("ascii9");
`ifndef ETH_TX_PAD_EN
    check_fcs_123456789("ascii9");
`endif

    // two 64-byte frames back to back: IFG of exactly 12 idle cycles
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i * 7 + 3));
    snap();
    send_payload(-1); send_payload(-1); wait_frames(2);
    check("b2b_gap", 64'(last_gap), 64'd12);
    check("b2b_ready_in_gap", 64'(rdy_gap - b_gap), 64'd0);
    check("b2b_bytes", 64'(rx_q.size() - b_rx), 64'd152);
    check("b2b_ready_cycles", 64'(rdy_cycles - b_rdy), 64'd128);

    // underrun after data byte 20, remaining bytes discarded
    pay.delete();
    for (int i = 0; i < 40; i++) pay.push_back(8'(8'hA0 + i));
    snap();
    send_payload(20); wait_frames(1);
    check("ur_len", 64'(rx_q.size() - b_rx), 64'd29);
    if (rx_q.size() - b_rx == 29) check("ur_last_byte", 64'(rx_q[b_rx+28]), 64'h00);
    check("ur_er_cycles", 64'(er_cycles - b_er), 64'd1);
    check("ur_pulse_cycles", 64'(ur_cycles - b_ur), 64'd1);
    check("ur_coincident", 64'(erur_cycles - b_erur), 64'd1);
    check("ur_ready_cycles", 64'(rdy_cycles - b_rdy), 64'd41);
    check("ur_ready_after", 64'(s_ready), 64'd0);
    load_ascii9(); snap();
    send_payload(-1); wait_frames(1);
    check_frame("post_ur");

    // reset during DATA byte 10
    pay.delete();
    for (int i = 0; i < 30; i++) pay.push_back(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) push_byte(pay[i], 1'b0);
    s_data = pay[10];
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_en", 64'(gmii_tx_en), 64'd0);
    check("mid_rst_txd", 64'(gmii_txd), 64'h00);
    check("mid_rst_state", 64'(dut.r_state), 64'(ST_IDLE));
    check("mid_rst_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    load_ascii9(); snap();
    send_payload(-1); wait_frames(1);
    check_frame("post_rst");
`ifndef ETH_TX_PAD_EN
    check_fcs_123456789("post_rst");
`endif

    // single byte payload, valid and last together
    pay.delete(); pay.push_back(8'hA5);
    snap();
    send_payload(-1); wait_frames(1);
    check("one_ready_cycles", 64'(rdy_cycles - b_rdy), 64'd1);
    check_frame("one");

    // 14-byte payload: padded to 64 bytes SFD-to-end when padding is built in
    pay.delete();
    for (int i = 0; i < 14; i++) pay.push_back(8'(8'hC0 ^ i));
    snap();
    send_payload(-1); wait_frames(1);
    check_frame("short14");
`ifdef ETH_TX_PAD_EN
    check("short14_sfd_to_end", 64'(rx_q.size() - b_rx - 8), 64'd64);
`else
    check("short14_sfd_to_end", 64'(rx_q.size() - b_rx - 8), 64'd18);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60, minimum bytes between SFD and FCS.
REQ-002 SHALL have parameter IFG_BYTES, default 12, idle cycles after FCS.
REQ-003 SHALL have port clk, input, 1, 125 MHz GMII transmit clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port s_data, input, 8, payload byte (DA first).
REQ-006 SHALL have port s_valid, input, 1, s_data valid.
REQ-007 SHALL have port s_last, input, 1, marks last payload byte.
REQ-008 SHALL have port s_ready, output, 1, byte accepted when s_valid & s_ready.
REQ-009 SHALL have port gmii_txd, output, 8, transmit byte.
REQ-010 SHALL have port gmii_tx_en, output, 1, frame in progress.
REQ-011 SHALL have port gmii_tx_er, output, 1, transmit error.
REQ-012 SHALL have port underrun, output, 1, one-cycle pulse on frame abort.

Function
REQ-013 SHALL register all gmii outputs: the state in cycle t determines the gmii byte in cycle t+1.
REQ-014 SHALL use states IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE→PRE when s_valid=1.
- PRE: 7 bytes of 0x55, then →SFD.
- SFD: 0xD5, then →DATA.
- DATA: s_ready=1. On s_last go →PAD if byte count < MIN_FRAME, else →FCS.
- PAD: 0x00 until the count reaches MIN_FRAME, then →FCS.
- FCS: 4 bytes, then →IFG.
- IFG: IFG_BYTES cycles, then →IDLE.
REQ-015 s_ready SHALL be 1 only in DATA, combinationally from state; an accepted byte SHALL appear on gmii_txd the next cycle.
REQ-016 gmii_tx_en SHALL be 1 from the first preamble byte through the last FCS byte inclusive, contiguous, and 0 otherwise.
REQ-017 CRC SHALL initialise to 0xFFFFFFFF on the SFD cycle.
REQ-018 CRC SHALL update on every DATA and PAD byte, with each byte bit-reversed before entering the LFSR (polynomial 0x04C11DB7).
REQ-019 FCS octet k (k=0..3, sent in order) SHALL be ~bitrev(crc[31-8k:24-8k]).
REQ-020 The byte counter SHALL be 16 bits and saturate at 0xFFFF; no maximum-length enforcement.
REQ-021 An s_valid=0 in DATA SHALL be an underrun, handled as follows.
- That cycle: drive gmii_txd=0x00 with gmii_tx_er=1 and tx_en=1, and pulse underrun.
- Then go →IFG with no FCS.
- Then silently drop s_data bytes up to and including s_last, with s_ready=1 while discarding.
REQ-022 s_valid asserted during IFG SHALL be ignored until IDLE; back-to-back frames SHALL be spaced by exactly IFG_BYTES idle cycles.

Reset
REQ-023 rst SHALL force state IDLE with s_ready=0, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, underrun=0, crc=0xFFFFFFFF and counters=0.
REQ-024 rst mid-frame SHALL truncate the frame immediately, with tx_en=0 in the first cycle after assertion and no FCS.

Configuration
REQ-025 With ETH_TX_PAD_EN defined, the PAD state and MIN_FRAME padding SHALL be present.
REQ-026 With ETH_TX_PAD_EN undefined, DATA SHALL always go →FCS on s_last and MIN_FRAME SHALL be unused.

Structure
REQ-027 Package eth_pkg SHALL hold the following.
- State enum.
- Constants ETH_PREAMBLE=0x55, ETH_SFD=0xD5, CRC_INIT=0xFFFFFFFF and CRC_RESIDUE=0xC704DD7B.
- Function bitrev8.
REQ-028 Sub-module eth_tx_crc32 SHALL hold the byte-wide CRC-32 LFSR with synchronous init and en inputs; the framer SHALL contain the FSM, counters and output mux.

Verification
REQ-029 ETH_TX_PAD_EN undefined, payload ASCII "123456789" → 0x55×7, D5, 31..39, then FCS 26 39 F4 CB; tx_en high for 21 cycles.
REQ-030 ETH_TX_PAD_EN defined, 14-byte payload → 46 bytes of 0x00 pad, 64 bytes SFD-to-end, and reference-model CRC over payload+pad+FCS = CRC_RESIDUE.
REQ-031 Two 64-byte frames offered back-to-back → exactly 12 idle cycles between tx_en fall and next rise; s_ready=0 throughout IFG.
REQ-032 s_valid dropped after data byte 20 → one cycle txd=00 with tx_er=1 and underrun=1, no FCS, and the rest of the frame to s_last is consumed and discarded.
REQ-033 rst pulsed in DATA byte 10 → next cycle tx_en=0, txd=00 and state IDLE; the following frame is correct with a fresh CRC.
REQ-034 1-byte payload with s_valid and s_last together in the first DATA cycle → s_ready high exactly 1 cycle, then pad/FCS per configuration.
